log_event_arbiter: RTL and testbench
====================================

// Module: log_event_arbiter
// PURPOSE
// - Round-robin arbiter sharing one log-event sink between NB_REQ requesters (FSMs, checkers).
// - Filters events below a runtime verbosity level and counts discarded events.
// - Registers the granted event towards the sink over a valid/ready handshake.
// - Sits between RTL event sources and the single event-capture/trace channel.
// PARAMETERS
// - NB_REQ   default 4   number of requesters, 2..16
// - ID_W     default 8   message-ID width per event
// - CNT_W    default 16  width of filtered-event counter
// PORTS
// - aclk           in   1             clock
// - aresetn        in   1             asynchronous reset, active-low
// - req_valid      in   NB_REQ        event present, per requester
// - req_ready      out  NB_REQ        event consumed (granted or filtered), per requester
// - req_level      in   NB_REQ*3      severity, requester i at [3*i+:3]
// - req_id         in   NB_REQ*ID_W   message ID, requester i at [ID_W*i+:ID_W]
// - cfg_verbosity  in   3             minimum level forwarded
// - out_valid      out  1             event held for sink
// - out_ready      in   1             sink accepts event
// - out_level      out  3             severity of held event
// - out_id         out  ID_W          ID of held event
// - out_src        out  $clog2(NB_REQ) index of originating requester
// - filt_count     out  CNT_W         saturating count of filtered events
// BEHAVIOUR
// - Levels: 0 DEBUG, 1 INFO, 2 WARNING, 3 CRITICAL, 4 ERROR; 5..7 treated as ERROR.
// - Reset: out_valid=0, out_level=0, out_id=0, out_src=0, filt_count=0, rr pointer=0, state=EMPTY.
// - req_ready is combinational; a requester holds valid/level/id stable until ready.
// - Filter: requester with valid=1 and level<cfg_verbosity gets ready=1 the same cycle, any
//   state; event discarded; filt_count += number filtered that cycle, saturates at all-ones.
// - Eligible: valid=1 and level>=cfg_verbosity. At most one eligible granted per cycle.
// - Load condition: state==EMPTY, or state==FULL and out_ready=1 (back-to-back, no bubble).
// - Grant: on load condition, first eligible index scanning ptr, ptr+1, ... mod NB_REQ;
//   granted requester gets ready=1; event registered, out_valid=1 next cycle (latency 1).
// - Pointer: after a grant to index g, ptr <= (g+1) mod NB_REQ; unchanged without grant.
// - FSM EMPTY: grant -> FULL; no grant -> EMPTY.
// - FSM FULL: out_ready=0 -> FULL, outputs stable; out_ready=1 & grant -> FULL, new event;
//   out_ready=1 & no grant -> EMPTY, out_valid=0.
// - Ungranted eligible requesters see ready=0 and retry; no event lost or duplicated.
// - cfg_verbosity change takes effect same cycle; a held out event is never recalled.
// - Reset mid-transfer drops held event; filt_count clears.
// - Simultaneous filtered + granted in same cycle both complete.
// CONFIGURATION
// - LOG_ARB_TRACE_EN defined: instantiates an svlogger ("LogArb", SVL_VERBOSE_DEBUG,
//   SVL_ROUTE_TERM); debug line per grant (src, level, id), warning on filt_count saturation.
//   Simulation only.
// - Undefined: no svlogger include or instance; fully synthesizable; cycle behaviour identical.
// TESTING
// - Reset; cfg_verbosity=0; req0 valid lvl=1 id=0x11; out_ready=1 -> out_valid next cycle,
//   out_src=0, out_id=0x11, req_ready[0] pulses once.
// - All 4 valid, lvl=2, out_ready=1, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles,
//   out_valid continuously high.
// - cfg_verbosity=3; req1 lvl=1, req2 lvl=4 same cycle -> req1 filtered (filt_count=1),
//   req2 forwarded with out_src=2.
// - out_ready=0 for 5 cycles with out event held -> out_* stable, no eligible req_ready,
//   then out_ready=1 -> next event loads with no bubble.
// - CNT_W=4, 20 filtered events -> filt_count sticks at 0xF.
// - Assert aresetn=0 while out_valid=1 -> out_valid=0 immediately, filt_count=0, ptr=0
//   after release.

Source files
------------

// File: rtl/log_event_arbiter.sv
// log_event_arbiter
// Round-robin arbiter sharing one log-event sink between NB_REQ requesters.
// Events whose severity is below cfg_verbosity are acknowledged and discarded
// in the same cycle and counted in a saturating counter. The granted event is
// registered and offered to the sink over a valid/ready handshake.
// Build option: define LOG_ARB_TRACE_EN to attach a simulation-only trace
// (grants and counter saturation). Cycle behaviour is identical either way.
module log_event_arbiter #(
  parameter int NB_REQ = 4,
  parameter int ID_W   = 8,
  parameter int CNT_W  = 16,
  localparam int SRC_W = $clog2(NB_REQ)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NB_REQ-1:0]        req_valid,
  output logic [NB_REQ-1:0]        req_ready,
  input  logic [3*NB_REQ-1:0]      req_level,
  input  logic [ID_W*NB_REQ-1:0]   req_id,
  input  logic [2:0]               cfg_verbosity,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_level,
  output logic [ID_W-1:0]          out_id,
  output logic [SRC_W-1:0]         out_src,
  output logic [CNT_W-1:0]         filt_count
);

  localparam int FC_W = $clog2(NB_REQ + 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SRC_W-1:0]  ptr_q;
  logic [NB_REQ-1:0] filt, elig, gnt_vec;
  logic [FC_W-1:0]   filt_n;
  logic [SRC_W:0]    scan_idx;
  logic [SRC_W-1:0]  gnt_idx;
  logic              found, load, grant;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  // Severities 5..7 behave as ERROR (4) when compared against the threshold.
  function automatic logic [2:0] eff_level(input logic [2:0] lvl);
    return (lvl > 3'd4) ? 3'd4 : lvl;
  endfunction

  // Split valid requests into filtered (below threshold) and eligible ones.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    filt   = '0;
    elig   = '0;
    filt_n = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (req_valid[i]) begin
        if (eff_level(req_level[3*i +: 3]) < cfg_verbosity) begin
          filt[i] = 1'b1;
          filt_n  = filt_n + FC_W'(1);
        end else begin
          elig[i] = 1'b1;
        end
      end
    end
  end

  // Round-robin scan: first eligible index starting at ptr_q, wrapping at NB_REQ.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (scan_idx >= (SRC_W+1)'(NB_REQ)) begin
        scan_idx = scan_idx - (SRC_W+1)'(NB_REQ);
      end
      if (!found && elig[scan_idx[SRC_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan_idx[SRC_W-1:0];
      end
    end
  end

  // The output register may load when empty or when the sink takes the held event.
  assign load  = (state_q == EMPTY) || out_ready;
  assign grant = load && found;

  // Acknowledge filtered requesters plus the single granted one.
  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      gnt_vec[i] = grant && (gnt_idx == SRC_W'(i));
    end
  end

  assign req_ready = filt | gnt_vec;

  // Saturating accumulation of this cycle's filtered events.
  assign cnt_sum  = {1'b0, filt_count} + (CNT_W+1)'(filt_n);
  assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  // Next-state logic of the output-holding FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (out_ready) state_d = grant ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register, round-robin pointer and filtered-event counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!aresetn) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      filt_count <= '0;
    end else begin
      state_q    <= state_d;
      filt_count <= cnt_next;
      if (grant) begin
        ptr_q <= (gnt_idx == SRC_W'(NB_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
    end
  end

  // Held event towards the sink; only replaced on a grant, never recalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_level <= '0;
      out_id    <= '0;
      out_src   <= '0;
    end else if (grant) begin
      out_level <= req_level[3*gnt_idx +: 3];
      out_id    <= req_id[ID_W*gnt_idx +: ID_W];
      out_src   <= gnt_idx;
    end
  end

  assign out_valid = (state_q == FULL);

`ifdef LOG_ARB_TRACE_EN
  // Trace each grant and the cycle the filtered counter pins at all-ones.
  always @(posedge aclk) begin
    if (aresetn && grant) begin
      $display("[LogArb][DEBUG] %0t grant src=%0d level=%0d id=0x%0h", $time, gnt_idx,
               req_level[3*gnt_idx +: 3], req_id[ID_W*gnt_idx +: ID_W]);
    end
    if (aresetn && (filt_count != '1) && (cnt_next == '1)) begin
      $display("[LogArb][WARNING] %0t filtered-event counter saturated", $time);
    end
  end
`endif

endmodule

// File: tb/tb_log_event_arbiter.sv
// Self-checking bench for log_event_arbiter (NB_REQ=4, ID_W=8, CNT_W=4).
// A transaction-level model computes, per cycle, which requesters must be
// acknowledged and what event the sink must see, from the arbitration rules.
module tb_log_event_arbiter;
  localparam int NB_REQ  = 4;
  localparam int ID_W    = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic [NB_REQ-1:0]      req_valid = '0;
  logic [NB_REQ-1:0]      req_ready;
  logic [3*NB_REQ-1:0]    req_level = '0;
  logic [ID_W*NB_REQ-1:0] req_id = '0;
  logic [2:0]             cfg_verbosity = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [2:0]             out_level;
  logic [ID_W-1:0]        out_id;
  logic [1:0]             out_src;
  logic [CNT_W-1:0]       filt_count;

  log_event_arbiter #(.NB_REQ(NB_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_level(req_level), .req_id(req_id),
    .cfg_verbosity(cfg_verbosity),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_level(out_level), .out_id(out_id), .out_src(out_src),
    .filt_count(filt_count)
  );

  always #5 aclk = ~aclk;

  // Requester-side pending events.
  bit              rv [NB_REQ];
  logic [2:0]      rl [NB_REQ];
  logic [ID_W-1:0] ri [NB_REQ];

  // Reference model: what the sink holds, the rotation start and the counter.
  bit              m_full;
  logic [2:0]      m_level;
  logic [ID_W-1:0] m_id;
  logic [1:0]      m_src;
  int              m_ptr;
  int              m_cnt;
  logic [NB_REQ-1:0] exp_ready, obs_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic int eff(input logic [2:0] l);
    return (l > 3'd4) ? 4 : int'(l);
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_level = '0; m_id = '0; m_src = '0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      rv[i] = 1'b0; rl[i] = '0; ri[i] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NB_REQ; i++) begin
      req_valid[i]          = rv[i];
      req_level[3*i +: 3]   = rl[i];
      req_id[ID_W*i +: ID_W] = ri[i];
    end
  endtask

  // One clock: apply requests, sample acknowledgements mid-cycle, advance the
  // model, then return 1 time unit after the edge with consumed events retired.
  task automatic tick();
    int  filt_n;
    bit  found;
    int  g;
    drive();
    @(negedge aclk);
    obs_ready = req_ready;
    exp_ready = '0;
    filt_n = 0; found = 1'b0; g = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (rv[i] && eff(rl[i]) < int'(cfg_verbosity)) begin
        exp_ready[i] = 1'b1;
        filt_n++;
      end
    end
    if (!m_full || out_ready) begin
      for (int k = 0; k < NB_REQ; k++) begin
        if (!found && rv[(m_ptr + k) % NB_REQ] &&
            eff(rl[(m_ptr + k) % NB_REQ]) >= int'(cfg_verbosity)) begin
          found = 1'b1;
          g = (m_ptr + k) % NB_REQ;
        end
      end
      if (found) begin
        exp_ready[g] = 1'b1;
        m_full  = 1'b1;
        m_level = rl[g];
        m_id    = ri[g];
        m_src   = 2'(g);
        m_ptr   = (g + 1) % NB_REQ;
      end else begin
        m_full = 1'b0;
      end
    end
    m_cnt = (m_cnt + filt_n > CNT_MAX) ? CNT_MAX : m_cnt + filt_n;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NB_REQ; i++) begin
      if (exp_ready[i]) rv[i] = 1'b0;
    end
    cyc++;
  endtask

  task automatic apply_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    model_reset();
    drive();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive();
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if ({out_valid, out_level, out_id, out_src, filt_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b lvl=%0d id=%h src=%0d cnt=%0d, required all zero",
               out_valid, out_level, out_id, out_src, filt_count);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_single();
    apply_reset();
    cfg_verbosity = 3'd0; out_ready = 1'b1;
    rv[0] = 1'b1; rl[0] = 3'd1; ri[0] = 8'h11;
    tick();
    n_checks++;
    if (obs_ready !== 4'b0001 || obs_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL single_ready: got %b required %b", obs_ready, exp_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_id !== 8'h11 || out_level !== 3'd1) begin
      n_fail++;
      $display("FAIL single_out: valid=%b src=%0d id=%h lvl=%0d required 1/0/11/1",
               out_valid, out_src, out_id, out_level);
    end
    tick();
    n_checks++;
    if (obs_ready !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_once: ready=%b valid=%b required 0000/0", obs_ready, out_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    cfg_verbosity = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < NB_REQ; i++) begin
      rv[i] = 1'b1; rl[i] = 3'd2; ri[i] = 8'(8'h20 + i);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(n % NB_REQ) || out_id !== m_id) begin
        n_fail++;
        $display("FAIL rr_grant cycle %0d: valid=%b src=%0d id=%h required 1/%0d/%h",
                 n, out_valid, out_src, out_id, n % NB_REQ, m_id);
      end
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rr_ready cycle %0d: got %b required %b", n, obs_ready, exp_ready);
      end
      for (int i = 0; i < NB_REQ; i++) begin
        if (!rv[i]) begin
          rv[i] = 1'b1; ri[i] = ri[i] + 8'h10;
        end
      end
    end
  endtask

  task automatic test_filter();
    apply_reset();
    cfg_verbosity = 3'd3; out_ready = 1'b1;
    rv[1] = 1'b1; rl[1] = 3'd1; ri[1] = 8'h31;
    rv[2] = 1'b1; rl[2] = 3'd4; ri[2] = 8'h42;
    tick();
    n_checks++;
    if (obs_ready !== 4'b0110) begin
      n_fail++;
      $display("FAIL filter_ready: got %b required 0110", obs_ready);
    end
    n_checks++;
    if (filt_count !== 4'd1 || out_valid !== 1'b1 || out_src !== 2'd2 || out_id !== 8'h42) begin
      n_fail++;
      $display("FAIL filter_out: cnt=%0d valid=%b src=%0d id=%h required 1/1/2/42",
               filt_count, out_valid, out_src, out_id);
    end
  endtask

  task automatic test_backpressure();
    logic [ID_W-1:0] held_id;
    apply_reset();
    cfg_verbosity = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < NB_REQ; i++) begin
      rv[i] = 1'b1; rl[i] = 3'd3; ri[i] = 8'(8'h50 + i);
    end
    tick();
    held_id = ri[0];
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++;
      if (obs_ready !== 4'b0000 || out_valid !== 1'b1 || out_src !== 2'd0 || out_id !== held_id) begin
        n_fail++;
        $display("FAIL stall cycle %0d: ready=%b valid=%b src=%0d id=%h required 0000/1/0/%h",
                 n, obs_ready, out_valid, out_src, out_id, held_id);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_id !== 8'h51 || obs_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b src=%0d id=%h ready=%b required 1/1/51/0010",
               out_valid, out_src, out_id, obs_ready);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cfg_verbosity = 3'd4; out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NB_REQ; i++) begin
        rv[i] = 1'b1; rl[i] = 3'($urandom_range(0, 3)); ri[i] = 8'($urandom);
      end
      tick();
      n_checks++;
      if (filt_count !== 4'(m_cnt) || obs_ready !== 4'b1111 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_step %0d: cnt=%0d ready=%b valid=%b required %0d/1111/0",
                 n, filt_count, obs_ready, out_valid, m_cnt);
      end
    end
    n_checks++;
    if (filt_count !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_final: cnt=%h required F", filt_count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    cfg_verbosity = 3'd1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) cfg_verbosity = 3'($urandom_range(0, 4));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NB_REQ; i++) begin
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1; rl[i] = 3'($urandom_range(0, 7)); ri[i] = 8'($urandom);
        end
      end
      tick();
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ready cycle %0d: got %b required %b", cyc, obs_ready, exp_ready);
      end
      n_checks++;
      if (out_valid !== m_full ||
          (m_full && {out_src, out_level, out_id} !== {m_src, m_level, m_id})) begin
        n_fail++;
        $display("FAIL rand_out cycle %0d: valid=%b src=%0d lvl=%0d id=%h required %b/%0d/%0d/%h",
                 cyc, out_valid, out_src, out_level, out_id, m_full, m_src, m_level, m_id);
      end
      n_checks++;
      if (filt_count !== 4'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt cycle %0d: got %0d required %0d", cyc, filt_count, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cfg_verbosity = 3'd2; out_ready = 1'b0;
    rv[0] = 1'b1; rl[0] = 3'd1; ri[0] = 8'h60;
    rv[3] = 1'b1; rl[3] = 3'd3; ri[3] = 8'h63;
    tick();
    n_checks++;
    if (obs_ready !== 4'b1001 || out_valid !== 1'b1 || out_src !== 2'd3 || filt_count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_setup: ready=%b valid=%b src=%0d cnt=%0d required 1001/1/3/1",
               obs_ready, out_valid, out_src, filt_count);
    end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || filt_count !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b cnt=%0d required 0/0", out_valid, filt_count);
    end
    model_reset();
    drive();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    cfg_verbosity = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < NB_REQ; i++) begin
      rv[i] = 1'b1; rl[i] = 3'd3; ri[i] = 8'(8'h70 + i);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_id !== 8'h70) begin
      n_fail++;
      $display("FAIL mid_ptr: valid=%b src=%0d id=%h required 1/0/70", out_valid, out_src, out_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_filter();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
